trunc_error_sweeper: RTL and testbench



---
 rtl/trunc_error_sweeper.sv | 190 +++++++++++++++++++
 tb/tb_trunc_error_sweeper.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trunc_error_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : trunc_error_sweeper
// Description : Exhaustive error sweeper for a partitioned sub-circuit and its
//               approximated variant. Drives every input vector in ascending
//               order and accumulates error metrics over the sampled
//               responses.
//
// Ports       : clk          - single clock, rising edge
//               rst          - synchronous reset, active-high
//               start        - one-cycle sweep request (ignored while busy)
//               pi_out       - input vector driven to both partitions
//               po_exact     - exact partition response
//               po_approx    - approximate partition response
//               busy         - high while sweeping or draining
//               done         - high from sweep completion until next start/rst
//               mismatch_cnt - vectors where po_exact != po_approx
//               bit_err_cnt  - saturating sum of popcount(po_exact ^ po_approx)
//               max_abs_err  - max |po_exact - po_approx| (unsigned operands)
//
// Revision    : 1.0 - initial release
// ============================================================================
module trunc_error_sweeper #(
    parameter int NUM_IN  = 7,
    parameter int NUM_OUT = 4,
    parameter int LAT     = 1,
    parameter int ACC_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [NUM_IN-1:0]  pi_out,
    input  logic [NUM_OUT-1:0] po_exact,
    input  logic [NUM_OUT-1:0] po_approx,
    output logic               busy,
    output logic               done,
    output logic [NUM_IN:0]    mismatch_cnt,
    output logic [ACC_W-1:0]   bit_err_cnt,
    output logic [NUM_OUT-1:0] max_abs_err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SWEEP = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int c_PW = $clog2(NUM_OUT + 1);
    localparam logic [NUM_IN-1:0] c_LAST_VEC = {NUM_IN{1'b1}};
    // Drain counter only has to reach LAT-1; keep it at least one bit wide.
    localparam int c_DW = (LAT < 2) ? 1 : $clog2(LAT);
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'((LAT > 0) ? LAT - 1 : 0);

    logic [1:0]         r_state;
    logic [NUM_IN-1:0]  r_cnt;
    logic [c_DW-1:0]    r_drain;
    logic               r_busy;
    logic               r_done;
    logic [NUM_IN:0]    r_mism;
    logic [ACC_W-1:0]   r_bits;
    logic [NUM_OUT-1:0] r_max;

    logic               w_drive;
    logic               w_sample;
    logic [NUM_OUT-1:0] w_diff_bits;
    logic [c_PW-1:0]    w_popcnt;
    logic [NUM_OUT-1:0] w_abs_err;
    logic [ACC_W:0]     w_bits_sum;
    logic [ACC_W-1:0]   w_bits_next;

    // A vector is driven in every SWEEP cycle; its tag marks when the
    // partition response for that vector is valid.
    assign w_drive = (r_state == c_SWEEP);

    generate
        if (LAT > 0) begin : g_tag_pipe
            logic [LAT-1:0] r_tag;
            logic [LAT:0]   w_tag_shift;

            assign w_tag_shift = {r_tag, w_drive};

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag <= '0;
                end else begin
                    r_tag <= w_tag_shift[LAT-1:0];
                end
            end

            assign w_sample = r_tag[LAT-1];
        end else begin : g_no_tag_pipe
            assign w_sample = w_drive;
        end
    endgenerate

    // Per-vector error terms.
    assign w_diff_bits = po_exact ^ po_approx;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_popcnt = w_popcnt + c_PW'(w_diff_bits[i]);
        end
    end

    // Ordering the operands first keeps the magnitude exact without needing
    // a sign bit: the result always fits in NUM_OUT bits.
    assign w_abs_err = (po_exact >= po_approx) ? (po_exact - po_approx)
                                               : (po_approx - po_exact);

    // One extra bit catches the carry out so the accumulator clamps
    // instead of wrapping.
    assign w_bits_sum  = {1'b0, r_bits} + (ACC_W + 1)'(w_popcnt);
    assign w_bits_next = w_bits_sum[ACC_W] ? {ACC_W{1'b1}} : w_bits_sum[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mism  <= '0;
            r_bits  <= '0;
            r_max   <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state <= c_SWEEP;
                        r_cnt   <= '0;
                        r_drain <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_mism  <= '0;
                        r_bits  <= '0;
                        r_max   <= '0;
                    end
                end
                c_SWEEP: begin
                    // Counter parks on the last vector; it holds through DRAIN.
                    if (r_cnt == c_LAST_VEC) begin
                        r_drain <= '0;
                        if (LAT == 0) begin
                            r_state <= c_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_DRAIN;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DRAIN: begin
                    // The last tag is sampled in the final DRAIN cycle.
                    if (r_drain == c_DRAIN_LAST) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Samples only occur in SWEEP/DRAIN, never alongside a start.
            if (w_sample) begin
                if (w_diff_bits != '0) begin
                    r_mism <= r_mism + 1'b1;
                end
                r_bits <= w_bits_next;
                if (w_abs_err > r_max) begin
                    r_max <= w_abs_err;
                end
            end
        end
    end

    assign pi_out       = r_cnt;
    assign busy         = r_busy;
    assign done         = r_done;
    assign mismatch_cnt = r_mism;
    assign bit_err_cnt  = r_bits;
    assign max_abs_err  = r_max;

endmodule
`default_nettype wire

// File: tb/tb_trunc_error_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_trunc_error_sweeper
// Description : Self-checking bench for trunc_error_sweeper. Four instances
//               (LAT/ACC_W = 1/16, 3/16, 1/8, 0/16) sweep shared truth tables
//               through behavioural partition models; results are compared
//               against a table-driven reference computation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trunc_error_sweeper;

    localparam int c_NV   = 128;
    localparam int c_NDUT = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;

    always #5 clk = ~clk;

    logic [6:0]  pi    [c_NDUT];
    logic [3:0]  ex    [c_NDUT];
    logic [3:0]  ap    [c_NDUT];
    logic        busy  [c_NDUT];
    logic        done  [c_NDUT];
    logic [7:0]  mism  [c_NDUT];
    logic [3:0]  maxe  [c_NDUT];
    logic [31:0] bits  [c_NDUT];
    logic [15:0] w_b0, w_b1, w_b3;
    logic [7:0]  w_b2;

    assign bits[0] = 32'(w_b0);
    assign bits[1] = 32'(w_b1);
    assign bits[2] = 32'(w_b2);
    assign bits[3] = 32'(w_b3);

    // Partition truth tables (shared by all instances).
    logic [3:0] ex_tab [c_NV];
    logic [3:0] ap_tab [c_NV];
    logic       skew;   // instance 1: approx path one stage shorter

    // Behavioural partitions: delay the input vector, then look up.
    logic [6:0] d0, d1a, d1b, d1c, d2;
    always @(posedge clk) begin
        d0  <= pi[0];
        d1a <= pi[1];
        d1b <= d1a;
        d1c <= d1b;
        d2  <= pi[2];
    end

    assign ex[0] = ex_tab[d0];
    assign ap[0] = ap_tab[d0];
    assign ex[1] = ex_tab[d1c];
    assign ap[1] = skew ? ap_tab[d1b] : ap_tab[d1c];
    assign ex[2] = ex_tab[d2];
    assign ap[2] = ap_tab[d2];
    assign ex[3] = ex_tab[pi[3]];
    assign ap[3] = ap_tab[pi[3]];

    trunc_error_sweeper #(.NUM_IN(7), .NUM_OUT(4), .LAT(1), .ACC_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .pi_out(pi[0]),
        .po_exact(ex[0]), .po_approx(ap[0]), .busy(busy[0]), .done(done[0]),
        .mismatch_cnt(mism[0]), .bit_err_cnt(w_b0), .max_abs_err(maxe[0]));

    trunc_error_sweeper #(.NUM_IN(7), .NUM_OUT(4), .LAT(3), .ACC_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .pi_out(pi[1]),
        .po_exact(ex[1]), .po_approx(ap[1]), .busy(busy[1]), .done(done[1]),
        .mismatch_cnt(mism[1]), .bit_err_cnt(w_b1), .max_abs_err(maxe[1]));

    trunc_error_sweeper #(.NUM_IN(7), .NUM_OUT(4), .LAT(1), .ACC_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .pi_out(pi[2]),
        .po_exact(ex[2]), .po_approx(ap[2]), .busy(busy[2]), .done(done[2]),
        .mismatch_cnt(mism[2]), .bit_err_cnt(w_b2), .max_abs_err(maxe[2]));

    trunc_error_sweeper #(.NUM_IN(7), .NUM_OUT(4), .LAT(0), .ACC_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .pi_out(pi[3]),
        .po_exact(ex[3]), .po_approx(ap[3]), .busy(busy[3]), .done(done[3]),
        .mismatch_cnt(mism[3]), .bit_err_cnt(w_b3), .max_abs_err(maxe[3]));

    int n_checks = 0;
    int n_errors = 0;

    function automatic int lat_of(input int i);
        case (i)
            1:       return 3;
            3:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int accw_of(input int i);
        return (i == 2) ? 8 : 16;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference metrics straight from the truth tables.
    task automatic model(input int accw, input bit skw,
                         output int e_m, output int e_b, output int e_x);
        int a_idx, e, a, cap;
        e_m = 0; e_b = 0; e_x = 0;
        for (int k = 0; k < c_NV; k++) begin
            a_idx = skw ? ((k + 1 > c_NV - 1) ? c_NV - 1 : k + 1) : k;
            e = int'(ex_tab[k]);
            a = int'(ap_tab[a_idx]);
            if (e != a) e_m++;
            e_b += $countones(ex_tab[k] ^ ap_tab[a_idx]);
            if ((e > a ? e - a : a - e) > e_x) e_x = (e > a ? e - a : a - e);
        end
        cap = (1 << accw) - 1;
        if (e_b > cap) e_b = cap;
    endtask

    task automatic set_tables(input int mode);
        for (int k = 0; k < c_NV; k++) begin
            ex_tab[k] = 4'(k);
            case (mode)
                1:       ap_tab[k] = 4'(k) ^ 4'b0001;
                2:       ap_tab[k] = 4'd0;
                3:       ap_tab[k] = ~4'(k);
                default: ap_tab[k] = 4'(k);
            endcase
        end
    endtask

    task automatic check_reset_state(input string ctx);
        for (int i = 0; i < c_NDUT; i++) begin
            chk($sformatf("%s_pi%0d", ctx, i),   32'(pi[i]),   0);
            chk($sformatf("%s_busy%0d", ctx, i), 32'(busy[i]), 0);
            chk($sformatf("%s_done%0d", ctx, i), 32'(done[i]), 0);
            chk($sformatf("%s_mism%0d", ctx, i), 32'(mism[i]), 0);
            chk($sformatf("%s_bits%0d", ctx, i), bits[i],      0);
            chk($sformatf("%s_max%0d", ctx, i),  32'(maxe[i]), 0);
        end
    endtask

    // Start a sweep and check cycle-by-cycle timing and the final metrics.
    // n counts cycles after the one in which start is sampled.
    task automatic run_sweep(input int restart_at);
        int l, m, b, x;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int n = 1; n <= 136; n++) begin
            if (n > 1) @(negedge clk);
            for (int i = 0; i < c_NDUT; i++) begin
                l = lat_of(i);
                chk($sformatf("busy%0d_n%0d", i, n), 32'(busy[i]), (n <= 128 + l) ? 1 : 0);
                chk($sformatf("done%0d_n%0d", i, n), 32'(done[i]), (n >= 129 + l) ? 1 : 0);
                if (n <= 128 + l)
                    chk($sformatf("pi%0d_n%0d", i, n), 32'(pi[i]), (n - 1 > 127) ? 127 : n - 1);
            end
            start = (n == restart_at);
        end
        start = 1'b0;
        for (int i = 0; i < c_NDUT; i++) begin
            model(accw_of(i), (i == 1) && skew, m, b, x);
            chk($sformatf("mism%0d", i), 32'(mism[i]), m);
            chk($sformatf("bits%0d", i), bits[i],      b);
            chk($sformatf("max%0d", i),  32'(maxe[i]), x);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        skew  = 1'b0;
        set_tables(0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst");

        // Directed sweeps: clean, LSB flip, stuck-at-zero, inverted.
        for (int mode = 0; mode < 4; mode++) begin
            set_tables(mode);
            run_sweep(0);
        end

        // Approx path one stage short on the LAT=3 instance.
        set_tables(0);
        skew = 1'b1;
        run_sweep(0);
        chk("skew_nonzero", 32'(mism[1] != 0), 1);
        skew = 1'b0;

        // Extra start while busy must not disturb anything.
        run_sweep(60);

        // Reset in the middle of a sweep (while vector 50 is driven).
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_pi0", 32'(pi[0]), 50);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_reset_state("mid");
        for (int n = 0; n < 140; n++) begin
            @(negedge clk);
            for (int i = 0; i < c_NDUT; i++) begin
                chk($sformatf("post_rst_done%0d", i), 32'(done[i]), 0);
                chk($sformatf("post_rst_busy%0d", i), 32'(busy[i]), 0);
            end
        end
        run_sweep(0);

        // start and rst together from DONE: reset wins.
        @(negedge clk) begin start = 1'b1; rst = 1'b1; end
        @(negedge clk) begin start = 1'b0; rst = 1'b0; end
        check_reset_state("both");

        // Randomized truth tables, skew and idle gaps.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < c_NV; k++) begin
                ex_tab[k] = 4'($urandom_range(0, 15));
                ap_tab[k] = ($urandom_range(0, 1) == 1) ? ex_tab[k] : 4'($urandom_range(0, 15));
            end
            skew = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_sweep(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 120)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
